// File: rtl/id_ex_reg.sv
// Decode/execute pipeline register with write-back-to-decode bypass,
// stall hold, flush bubble insertion and load-use hazard detection.
module id_ex_reg #(
    parameter int DATA_W = 16,
    parameter int CTRL_W = 12
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              idValid,
    input  logic [DATA_W-1:0] idReadData1,
    input  logic [DATA_W-1:0] idReadData2,
    input  logic [2:0]        idReadReg1Sel,
    input  logic [2:0]        idReadReg2Sel,
    input  logic [2:0]        idWriteRegSel,
    input  logic              idRegWriteEn,
    input  logic              idMemRead,
    input  logic              idMemWrite,
    input  logic [DATA_W-1:0] idImm,
    input  logic [DATA_W-1:0] idPcPlus2,
    input  logic [CTRL_W-1:0] idCtrl,
    input  logic              wbWriteEn,
    input  logic [2:0]        wbWriteRegSel,
    input  logic [DATA_W-1:0] wbWriteData,
    input  logic              stall,
    input  logic              flush,
    output logic              exValid,
    output logic [DATA_W-1:0] exReadData1,
    output logic [DATA_W-1:0] exReadData2,
    output logic [2:0]        exReadReg1Sel,
    output logic [2:0]        exReadReg2Sel,
    output logic [2:0]        exWriteRegSel,
    output logic              exRegWriteEn,
    output logic              exMemRead,
    output logic              exMemWrite,
    output logic [DATA_W-1:0] exImm,
    output logic [DATA_W-1:0] exPcPlus2,
    output logic [CTRL_W-1:0] exCtrl,
    output logic              loadUseStall,
    output logic              err
);

    logic              r_valid;
    logic [DATA_W-1:0] r_read_data1;
    logic [DATA_W-1:0] r_read_data2;
    logic [2:0]        r_read_reg1_sel;
    logic [2:0]        r_read_reg2_sel;
    logic [2:0]        r_write_reg_sel;
    logic              r_reg_write_en;
    logic              r_mem_read;
    logic              r_mem_write;
    logic [DATA_W-1:0] r_imm;
    logic [DATA_W-1:0] r_pc_plus2;
    logic [CTRL_W-1:0] r_ctrl;

    logic [DATA_W-1:0] w_operand1;
    logic [DATA_W-1:0] w_operand2;
    logic              w_src_match;

    // The register file write lands on the same edge we capture, so take the WB value directly.
    assign w_operand1 = (wbWriteEn && (wbWriteRegSel == idReadReg1Sel)) ? wbWriteData : idReadData1;
    assign w_operand2 = (wbWriteEn && (wbWriteRegSel == idReadReg2Sel)) ? wbWriteData : idReadData2;

    always_ff @(posedge clk) begin
        if (rst || flush) begin
            r_valid         <= 1'b0;
            r_read_data1    <= '0;
            r_read_data2    <= '0;
            r_read_reg1_sel <= '0;
            r_read_reg2_sel <= '0;
            r_write_reg_sel <= '0;
            r_reg_write_en  <= 1'b0;
            r_mem_read      <= 1'b0;
            r_mem_write     <= 1'b0;
            r_imm           <= '0;
            r_pc_plus2      <= '0;
            r_ctrl          <= '0;
        end else if (!stall) begin
            r_valid         <= idValid;
            r_read_data1    <= w_operand1;
            r_read_data2    <= w_operand2;
            r_read_reg1_sel <= idReadReg1Sel;
            r_read_reg2_sel <= idReadReg2Sel;
            r_write_reg_sel <= idWriteRegSel;
            r_reg_write_en  <= idRegWriteEn & idValid;
            r_mem_read      <= idMemRead & idValid;
            r_mem_write     <= idMemWrite & idValid;
            r_imm           <= idImm;
            r_pc_plus2      <= idPcPlus2;
            r_ctrl          <= idCtrl;
        end
    end

    assign exValid       = r_valid;
    assign exReadData1   = r_read_data1;
    assign exReadData2   = r_read_data2;
    assign exReadReg1Sel = r_read_reg1_sel;
    assign exReadReg2Sel = r_read_reg2_sel;
    assign exWriteRegSel = r_write_reg_sel;
    assign exRegWriteEn  = r_reg_write_en;
    assign exMemRead     = r_mem_read;
    assign exMemWrite    = r_mem_write;
    assign exImm         = r_imm;
    assign exPcPlus2     = r_pc_plus2;
    assign exCtrl        = r_ctrl;

    // Conservative: both sources compared whether or not the instruction reads them.
    assign w_src_match  = (r_write_reg_sel == idReadReg1Sel) || (r_write_reg_sel == idReadReg2Sel);
    assign loadUseStall = r_valid & r_mem_read & idValid & w_src_match;
    assign err          = stall & flush;

endmodule

// File: tb/tb_id_ex_reg.sv
// Self-checking bench for id_ex_reg: behavioural model compared every cycle,
// directed literal checks from the test plan, then randomized traffic.
module tb_id_ex_reg;

    localparam int DATA_W = 16;
    localparam int CTRL_W = 12;

    logic              clk = 1'b0;
    logic              rst;
    logic              idValid;
    logic [DATA_W-1:0] idReadData1, idReadData2;
    logic [2:0]        idReadReg1Sel, idReadReg2Sel, idWriteRegSel;
    logic              idRegWriteEn, idMemRead, idMemWrite;
    logic [DATA_W-1:0] idImm, idPcPlus2;
    logic [CTRL_W-1:0] idCtrl;
    logic              wbWriteEn;
    logic [2:0]        wbWriteRegSel;
    logic [DATA_W-1:0] wbWriteData;
    logic              stall, flush;
    logic              exValid;
    logic [DATA_W-1:0] exReadData1, exReadData2;
    logic [2:0]        exReadReg1Sel, exReadReg2Sel, exWriteRegSel;
    logic              exRegWriteEn, exMemRead, exMemWrite;
    logic [DATA_W-1:0] exImm, exPcPlus2;
    logic [CTRL_W-1:0] exCtrl;
    logic              loadUseStall, err;

    int errors = 0;
    int checks = 0;
    bit chk_en = 1'b0;

    id_ex_reg #(.DATA_W(DATA_W), .CTRL_W(CTRL_W)) dut (
        .clk(clk), .rst(rst), .idValid(idValid),
        .idReadData1(idReadData1), .idReadData2(idReadData2),
        .idReadReg1Sel(idReadReg1Sel), .idReadReg2Sel(idReadReg2Sel),
        .idWriteRegSel(idWriteRegSel), .idRegWriteEn(idRegWriteEn),
        .idMemRead(idMemRead), .idMemWrite(idMemWrite),
        .idImm(idImm), .idPcPlus2(idPcPlus2), .idCtrl(idCtrl),
        .wbWriteEn(wbWriteEn), .wbWriteRegSel(wbWriteRegSel), .wbWriteData(wbWriteData),
        .stall(stall), .flush(flush),
        .exValid(exValid), .exReadData1(exReadData1), .exReadData2(exReadData2),
        .exReadReg1Sel(exReadReg1Sel), .exReadReg2Sel(exReadReg2Sel),
        .exWriteRegSel(exWriteRegSel), .exRegWriteEn(exRegWriteEn),
        .exMemRead(exMemRead), .exMemWrite(exMemWrite),
        .exImm(exImm), .exPcPlus2(exPcPlus2), .exCtrl(exCtrl),
        .loadUseStall(loadUseStall), .err(err)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic              valid;
        logic [DATA_W-1:0] d1, d2;
        logic [2:0]        s1, s2, wr;
        logic              we, mr, mw;
        logic [DATA_W-1:0] imm, pc;
        logic [CTRL_W-1:0] ctrl;
    } ex_t;

    ex_t m = '0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference: what execute must hold after this edge, from the stage's rules.
    always @(posedge clk) begin
        if (rst || flush) begin
            m = '0;
        end else if (!stall) begin
            m.valid = idValid;
            m.d1    = (wbWriteEn && wbWriteRegSel == idReadReg1Sel) ? wbWriteData : idReadData1;
            m.d2    = (wbWriteEn && wbWriteRegSel == idReadReg2Sel) ? wbWriteData : idReadData2;
            m.s1    = idReadReg1Sel;
            m.s2    = idReadReg2Sel;
            m.wr    = idWriteRegSel;
            m.we    = idValid && idRegWriteEn;
            m.mr    = idValid && idMemRead;
            m.mw    = idValid && idMemWrite;
            m.imm   = idImm;
            m.pc    = idPcPlus2;
            m.ctrl  = idCtrl;
        end
    end

    always @(negedge clk) begin
        if (chk_en) begin
            chk("exValid",      64'(exValid),       64'(m.valid));
            chk("exReadData1",  64'(exReadData1),   64'(m.d1));
            chk("exReadData2",  64'(exReadData2),   64'(m.d2));
            chk("exReadReg1Sel",64'(exReadReg1Sel), 64'(m.s1));
            chk("exReadReg2Sel",64'(exReadReg2Sel), 64'(m.s2));
            chk("exWriteRegSel",64'(exWriteRegSel), 64'(m.wr));
            chk("exRegWriteEn", 64'(exRegWriteEn),  64'(m.we));
            chk("exMemRead",    64'(exMemRead),     64'(m.mr));
            chk("exMemWrite",   64'(exMemWrite),    64'(m.mw));
            chk("exImm",        64'(exImm),         64'(m.imm));
            chk("exPcPlus2",    64'(exPcPlus2),     64'(m.pc));
            chk("exCtrl",       64'(exCtrl),        64'(m.ctrl));
            chk("loadUseStall", 64'(loadUseStall),
                64'(m.valid && m.mr && idValid && (m.wr == idReadReg1Sel || m.wr == idReadReg2Sel)));
            chk("err",          64'(err),           64'(stall && flush));
        end
    end

    // One edge, then settle past the negedge compare before touching inputs.
    task automatic cyc();
        @(posedge clk);
        @(negedge clk);
        #2;
    endtask

    task automatic clear_inputs();
        idValid = 0; idReadData1 = 0; idReadData2 = 0;
        idReadReg1Sel = 0; idReadReg2Sel = 0; idWriteRegSel = 0;
        idRegWriteEn = 0; idMemRead = 0; idMemWrite = 0;
        idImm = 0; idPcPlus2 = 0; idCtrl = 0;
        wbWriteEn = 0; wbWriteRegSel = 0; wbWriteData = 0;
        stall = 0; flush = 0;
    endtask

    initial begin
        clear_inputs();
        rst = 1;
        cyc(); cyc();
        chk_en = 1'b1;
        rst = 0;
        cyc();
        chk("reset exValid", 64'(exValid), 64'd0);
        chk("reset exReadData1", 64'(exReadData1), 64'd0);
        chk("reset loadUseStall", 64'(loadUseStall), 64'd0);
        chk("reset err", 64'(err), 64'd0);
        $display("reset/idle done");

        idValid = 1; idReadReg1Sel = 2; idReadReg2Sel = 3;
        idReadData1 = 16'h1111; idReadData2 = 16'h2222; idImm = 16'hFFF0;
        cyc();
        chk("load d1", 64'(exReadData1), 64'h1111);
        chk("load d2", 64'(exReadData2), 64'h2222);
        chk("load imm", 64'(exImm), 64'hFFF0);
        chk("load valid", 64'(exValid), 64'd1);
        $display("plain load: d1=%h d2=%h imm=%h", exReadData1, exReadData2, exImm);

        wbWriteEn = 1; wbWriteRegSel = 3; wbWriteData = 16'hBEEF;
        idReadReg1Sel = 3; idReadReg2Sel = 3; idReadData1 = 0; idReadData2 = 0;
        cyc();
        chk("bypass d1", 64'(exReadData1), 64'hBEEF);
        chk("bypass d2", 64'(exReadData2), 64'hBEEF);
        wbWriteEn = 0;
        cyc();
        chk("nobypass d1", 64'(exReadData1), 64'h0);
        chk("nobypass d2", 64'(exReadData2), 64'h0);
        $display("bypass checks done");

        idReadReg1Sel = 1; idReadData1 = 16'h1234;
        cyc();
        chk("pre-stall d1", 64'(exReadData1), 64'h1234);
        stall = 1; idReadData1 = 16'hAAAA;
        for (int i = 0; i < 3; i++) begin
            cyc();
            chk("stall hold d1", 64'(exReadData1), 64'h1234);
        end
        stall = 0;
        cyc();
        chk("release d1", 64'(exReadData1), 64'hAAAA);
        $display("stall hold done");

        idMemWrite = 1;
        cyc();
        chk("store memwrite", 64'(exMemWrite), 64'd1);
        flush = 1;
        cyc();
        chk("flush valid", 64'(exValid), 64'd0);
        chk("flush memwrite", 64'(exMemWrite), 64'd0);
        flush = 0; idMemWrite = 0;
        cyc();
        stall = 1; flush = 1;
        #1;
        chk("err comb", 64'(err), 64'd1);
        cyc();
        chk("stall+flush bubble", 64'(exValid), 64'd0);
        stall = 0; flush = 0;
        $display("flush/err done");

        idValid = 1; idMemRead = 1; idRegWriteEn = 1; idWriteRegSel = 5;
        idReadReg1Sel = 0; idReadReg2Sel = 0;
        cyc();
        idMemRead = 0; idRegWriteEn = 0; idReadReg2Sel = 5;
        #1;
        chk("loaduse hit", 64'(loadUseStall), 64'd1);
        idValid = 0;
        #1;
        chk("loaduse idValid0", 64'(loadUseStall), 64'd0);
        idValid = 1; idReadReg1Sel = 4; idReadReg2Sel = 4;
        #1;
        chk("loaduse nomatch", 64'(loadUseStall), 64'd0);
        $display("load-use done");

        cyc();
        stall = 1;
        cyc();
        rst = 1;
        cyc();
        chk("rst mid-stall valid", 64'(exValid), 64'd0);
        rst = 0; stall = 0;
        $display("reset mid-stall done");

        for (int n = 0; n < 2000; n++) begin
            idValid       = 1'($urandom_range(0, 3) != 0);
            idReadData1   = 16'($urandom);
            idReadData2   = 16'($urandom);
            idReadReg1Sel = 3'($urandom);
            idReadReg2Sel = 3'($urandom);
            idWriteRegSel = 3'($urandom);
            idRegWriteEn  = 1'($urandom);
            idMemRead     = 1'($urandom);
            idMemWrite    = 1'($urandom);
            idImm         = 16'($urandom);
            idPcPlus2     = 16'($urandom);
            idCtrl        = 12'($urandom);
            wbWriteEn     = 1'($urandom);
            wbWriteRegSel = 3'($urandom);
            wbWriteData   = 16'($urandom);
            stall         = 1'($urandom_range(0, 4) == 0);
            flush         = 1'($urandom_range(0, 7) == 0);
            rst           = 1'($urandom_range(0, 49) == 0);
            cyc();
        end
        $display("random traffic done: 2000 cycles");

        chk_en = 1'b0;
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
